ysyx_22050243_ifu_fetch_ctrl: RTL and testbench

IF-stage fetch controller: owns the PC, issues one-outstanding instruction-bus requests, and fills the IF/ID register. It is the consumer of the ID-stage hazard and redirect outputs. `stall_id` (the OR of the jalr, load-use and other ID stall requests) freezes the IF/ID slot. `redirect_valid`/`redirect_pc` (jalr/branch target resolved in ID with forwarded rs1) steers the PC, squashes wrong-path fetches and flushes the slot.

---
 rtl/ysyx_22050243_pkg.sv | 16 +
 rtl/ysyx_22050243_ifu_fetch_ctrl_if.sv | 14 +
 rtl/ysyx_22050243_if_skid.sv | 47 ++++
 rtl/ysyx_22050243_ifu_fetch_ctrl.sv | 131 +++++++++++++
 tb/tb_ysyx_22050243_ifu_fetch_ctrl.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/ysyx_22050243_pkg.sv
// rtl/ysyx_22050243_pkg.sv - shared IF/ID constants and fetch-state enum
package ysyx_22050243_pkg;

  localparam int unsigned IBUS_ADDR_W = 32;
  localparam int unsigned IBUS_DATA_W = 32;
  localparam logic [31:0] RESET_PC    = 32'h8000_0000;
  localparam logic [31:0] INST_NOP    = 32'h0000_0013;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_FETCH = 2'd1,
    FS_WAIT  = 2'd2,
    FS_HOLD  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/ysyx_22050243_ifu_fetch_ctrl_if.sv
// rtl/ysyx_22050243_ifu_fetch_ctrl_if.sv - instruction bus request/response bundle
interface ysyx_22050243_ifu_fetch_ctrl_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] addr;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;

  modport master (output req_valid, addr, input req_ready, resp_valid, resp_data);
  modport slave  (input req_valid, addr, output req_ready, resp_valid, resp_data);
endinterface

// File: rtl/ysyx_22050243_if_skid.sv
// rtl/ysyx_22050243_if_skid.sv - single-entry instruction+pc skid buffer
module ysyx_22050243_if_skid #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          clear,
  input  logic [DW-1:0] load_inst,
  input  logic [AW-1:0] load_pc,
  output logic          valid,
  output logic [DW-1:0] inst,
  output logic [AW-1:0] pc
);
  logic          valid_q, valid_d;
  logic [DW-1:0] inst_q, inst_d;
  logic [AW-1:0] pc_q, pc_d;

  always_comb begin
    valid_d = valid_q;
    inst_d  = inst_q;
    pc_d    = pc_q;
    if (clear) valid_d = 1'b0;
    if (load) begin
      valid_d = 1'b1;
      inst_d  = load_inst;
      pc_d    = load_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      inst_q  <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      inst_q  <= inst_d;
      pc_q    <= pc_d;
    end
  end

  assign valid = valid_q;
  assign inst  = inst_q;
  assign pc    = pc_q;
endmodule

// File: rtl/ysyx_22050243_ifu_fetch_ctrl.sv
// rtl/ysyx_22050243_ifu_fetch_ctrl.sv - PC owner, one-outstanding fetch FSM, IF/ID slot
module ysyx_22050243_ifu_fetch_ctrl #(
  parameter int unsigned IBUS_ADDR_WIDTH = 32,
  parameter int unsigned IBUS_DATA_WIDTH = 32,
  parameter logic [IBUS_ADDR_WIDTH-1:0] RESET_PC = IBUS_ADDR_WIDTH'(ysyx_22050243_pkg::RESET_PC)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              stall_id,
  input  logic                              redirect_valid,
  input  logic [IBUS_ADDR_WIDTH-1:0]        redirect_pc,
  ysyx_22050243_ifu_fetch_ctrl_if.master    ibus,
  output logic                              inst_valid,
  output logic [IBUS_DATA_WIDTH-1:0]        inst,
  output logic [IBUS_ADDR_WIDTH-1:0]        inst_pc
);
  import ysyx_22050243_pkg::*;

  fetch_state_e               state_q, state_d;
  logic [IBUS_ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                       drop_q, drop_d;
  logic                       req_valid_q, req_valid_d;
  logic                       inst_valid_q, inst_valid_d;
  logic [IBUS_DATA_WIDTH-1:0] inst_q, inst_d;
  logic [IBUS_ADDR_WIDTH-1:0] inst_pc_q, inst_pc_d;

  logic                       skid_load, skid_clear, skid_valid;
  logic [IBUS_DATA_WIDTH-1:0] skid_inst;
  logic [IBUS_ADDR_WIDTH-1:0] skid_pc;
  logic                       slot_free, req_fire;

  ysyx_22050243_if_skid #(.AW(IBUS_ADDR_WIDTH), .DW(IBUS_DATA_WIDTH)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (skid_load),
    .clear     (skid_clear),
    .load_inst (ibus.resp_data),
    .load_pc   (pc_q),
    .valid     (skid_valid),
    .inst      (skid_inst),
    .pc        (skid_pc)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_d       = drop_q;
    inst_valid_d = inst_valid_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    skid_load    = 1'b0;
    skid_clear   = 1'b0;
    slot_free    = !inst_valid_q || !stall_id;
    req_fire     = req_valid_q && ibus.req_ready;

    if (!stall_id) inst_valid_d = 1'b0;

    if (redirect_valid) begin
      // A request accepted or still in flight must have its response swallowed.
      pc_d         = {redirect_pc[IBUS_ADDR_WIDTH-1:1], 1'b0};
      inst_valid_d = 1'b0;
      skid_clear   = 1'b1;
      drop_d       = 1'b0;
      state_d      = FS_FETCH;
      if ((state_q == FS_WAIT && !ibus.resp_valid) || (state_q == FS_FETCH && req_fire)) begin
        drop_d  = 1'b1;
        state_d = FS_WAIT;
      end
    end else begin
      case (state_q)
        FS_IDLE:  state_d = FS_FETCH;
        FS_FETCH: if (req_fire) state_d = FS_WAIT;
        FS_WAIT: begin
          if (ibus.resp_valid) begin
            state_d = FS_FETCH;
            if (drop_q) begin
              drop_d = 1'b0;
            end else if (slot_free) begin
              inst_valid_d = 1'b1;
              inst_d       = ibus.resp_data;
              inst_pc_d    = pc_q;
              pc_d         = pc_q + IBUS_ADDR_WIDTH'(4);
            end else begin
              skid_load = 1'b1;
              pc_d      = pc_q + IBUS_ADDR_WIDTH'(4);
              state_d   = FS_HOLD;
            end
          end
        end
        FS_HOLD: begin
          if (!stall_id && skid_valid) begin
            inst_valid_d = 1'b1;
            inst_d       = skid_inst;
            inst_pc_d    = skid_pc;
            skid_clear   = 1'b1;
            state_d      = FS_FETCH;
          end
        end
        default: state_d = FS_IDLE;
      endcase
    end

    req_valid_d = (state_d == FS_FETCH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FS_IDLE;
      pc_q         <= RESET_PC;
      drop_q       <= 1'b0;
      req_valid_q  <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_q       <= drop_d;
      req_valid_q  <= req_valid_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
    end
  end

  assign ibus.req_valid = req_valid_q;
  assign ibus.addr      = pc_q;
  assign inst_valid     = inst_valid_q;
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;
endmodule

// File: tb/tb_ysyx_22050243_ifu_fetch_ctrl.sv
// tb/tb_ysyx_22050243_ifu_fetch_ctrl.sv - directed bench for the IF fetch controller
module tb_ysyx_22050243_ifu_fetch_ctrl;
  logic        clk;
  logic        rst_n;
  logic        stall_id;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  int total = 0;
  int bad   = 0;
  int fires = 0;
  int fires_mark;

  ysyx_22050243_ifu_fetch_ctrl_if #(.ADDR_W(32), .DATA_W(32)) ibus ();

  ysyx_22050243_ifu_fetch_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall_id       (stall_id),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ibus           (ibus),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (ibus.req_valid && ibus.req_ready) fires++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_valid"},  {31'd0, ibus.req_valid}, 32'd0);
    chk({tag, "_inst_valid"}, {31'd0, inst_valid},     32'd0);
    chk({tag, "_inst"},       inst,                    32'd0);
    chk({tag, "_inst_pc"},    inst_pc,                 32'd0);
    chk({tag, "_addr"},       ibus.addr,               32'h8000_0000);
  endtask

  initial begin
    rst_n = 1'b0; stall_id = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    ibus.req_ready = 1'b0; ibus.resp_valid = 1'b0; ibus.resp_data = '0;
    step(); step();
    check_reset_outputs("rst");

    // basic fetch with zero-wait bus
    rst_n = 1'b1; ibus.req_ready = 1'b1;
    step();
    chk("e1_req_valid", {31'd0, ibus.req_valid}, 32'd1);
    chk("e1_addr", ibus.addr, 32'h8000_0000);
    step();
    chk("e2_req_valid", {31'd0, ibus.req_valid}, 32'd0);
    ibus.resp_valid = 1'b1; ibus.resp_data = 32'h0000_0013;
    step();
    ibus.resp_valid = 1'b0;
    chk("e3_inst_valid", {31'd0, inst_valid}, 32'd1);
    chk("e3_inst", inst, 32'h0000_0013);
    chk("e3_inst_pc", inst_pc, 32'h8000_0000);
    chk("e3_addr", ibus.addr, 32'h8000_0004);

    // stall while response arrives: park in skid
    stall_id = 1'b1;
    step();
    ibus.resp_valid = 1'b1; ibus.resp_data = 32'hAAAA_0001;
    step();
    ibus.resp_valid = 1'b0;
    chk("hold_req_valid0", {31'd0, ibus.req_valid}, 32'd0);
    chk("hold_inst_old", inst, 32'h0000_0013);
    chk("hold_inst_valid", {31'd0, inst_valid}, 32'd1);
    step();
    chk("hold_req_valid1", {31'd0, ibus.req_valid}, 32'd0);
    chk("hold_inst_pc_old", inst_pc, 32'h8000_0000);
    stall_id = 1'b0;
    step();
    chk("unpark_inst", inst, 32'hAAAA_0001);
    chk("unpark_inst_pc", inst_pc, 32'h8000_0004);
    chk("unpark_req_valid", {31'd0, ibus.req_valid}, 32'd1);
    chk("unpark_addr", ibus.addr, 32'h8000_0008);

    // redirect while waiting: response dropped
    step();
    chk("consume_inst_valid", {31'd0, inst_valid}, 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0101;
    step();
    redirect_valid = 1'b0;
    chk("drop_wait_req", {31'd0, ibus.req_valid}, 32'd0);
    ibus.resp_valid = 1'b1; ibus.resp_data = 32'hDEAD_BEEF;
    step();
    ibus.resp_valid = 1'b0;
    chk("drop_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("drop_req_valid", {31'd0, ibus.req_valid}, 32'd1);
    chk("drop_addr", ibus.addr, 32'h8000_0100);

    // redirect coinciding with response and stall
    step();
    ibus.resp_valid = 1'b1; ibus.resp_data = 32'h1111_2222;
    step();
    ibus.resp_valid = 1'b0;
    chk("pre_flush_inst", inst, 32'h1111_2222);
    chk("pre_flush_valid", {31'd0, inst_valid}, 32'd1);
    stall_id = 1'b1;
    step();
    ibus.resp_valid = 1'b1; ibus.resp_data = 32'h3333_4444;
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
    step();
    ibus.resp_valid = 1'b0; redirect_valid = 1'b0; stall_id = 1'b0;
    chk("flush_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("flush_req_valid", {31'd0, ibus.req_valid}, 32'd1);
    chk("flush_addr", ibus.addr, 32'h8000_0200);

    // backpressure and pc wrap
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; ibus.req_ready = 1'b0;
    step();
    redirect_valid = 1'b0;
    fires_mark = fires;
    chk("bp_addr0", ibus.addr, 32'hFFFF_FFFC);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk($sformatf("bp_addr%0d", i), ibus.addr, 32'hFFFF_FFFC);
      chk($sformatf("bp_req%0d", i), {31'd0, ibus.req_valid}, 32'd1);
    end
    ibus.req_ready = 1'b1;
    step();
    chk("bp_wait_req", {31'd0, ibus.req_valid}, 32'd0);
    ibus.resp_valid = 1'b1; ibus.resp_data = 32'h5555_6666;
    step();
    ibus.resp_valid = 1'b0;
    chk("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
    chk("wrap_addr", ibus.addr, 32'h0000_0000);
    chk("bp_single_req", fires - fires_mark, 32'd1);

    // async reset mid-WAIT
    step();
    chk("pre_rst_req", {31'd0, ibus.req_valid}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("async");
    step();
    rst_n = 1'b1;
    chk("rel_req_valid", {31'd0, ibus.req_valid}, 32'd0);
    step();
    chk("restart_req", {31'd0, ibus.req_valid}, 32'd1);
    chk("restart_addr", ibus.addr, 32'h8000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
